wb_ps2: RTL
===========

# wb_ps2

Wishbone B4 classic slave that receives scan codes from a PS/2 keyboard or mouse on the `ps2_clk`/`ps2_dat` pins. It samples the device-to-host serial frame, checks framing and parity, and buffers good bytes in a FIFO. The CPU reads the FIFO through two word registers. The block sits behind the peripheral arbiter alongside the UART, SPI flash and timer slaves, and can raise an interrupt toward the CPU interface.

## Interface
- `FIFO_DEPTH`, 16: receive FIFO entries; power of two, 2..256.
- `TIMEOUT`, 50000: `clk_i` cycles without a PS/2 clock falling edge before an in-progress frame is aborted.

Ports:
- `clk_i` in 1: system clock; the only clock.
- `rst_i` in 1: reset; synchronous, active-high.
- `cyc_i` in 1: Wishbone cycle.
- `stb_i` in 1: Wishbone strobe from the arbiter.
- `we_i` in 1: write enable.
- `adr_i` in 30: word address; only `adr_i[0]` is decoded.
- `sel_i` in 4: byte selects; writes honour `sel_i[0]` and `sel_i[2]` only.
- `dat_i` in 32: write data.
- `ack_o` out 1: single-cycle acknowledge.
- `dat_o` out 32: read data.
- `ps2_clk` in 1: asynchronous PS/2 clock pin.
- `ps2_dat` in 1: asynchronous PS/2 data pin.
- `irq_o` out 1: level interrupt.

## Operation
**Input conditioning**
- Both pins pass through a 2-FF synchronizer, then one history FF.
- A falling edge is history=1 and synchronized=0.

**Receive FSM** (advances only on falling edges, except timeout)
- IDLE: data=0 moves to DATA with bit count 0. data=1 is ignored (stray edge).
- DATA: shift data in LSB first. After 8 bits, move to PARITY.
- PARITY: latch the bit and move to STOP.
- STOP:
  - Stop=1 and odd parity over data+parity correct: push the byte.
  - Parity wrong: set PERR and discard the byte.
  - Stop=0: set FERR and discard the byte.
  - In all cases, return to IDLE.
- Timeout: a counter resets on every falling edge. If it reaches `TIMEOUT` in any non-IDLE state, set FERR, discard the partial frame and return to IDLE.

**FIFO**
- Push when full: drop the new byte, set OVR, leave contents unchanged.
- Push and pop in the same cycle: both occur; count unchanged.
- Pop when empty: no effect.

**Register map**
- Word 0, DATA:
  - Read returns `{23'b0, valid, byte}`. `valid` = FIFO not empty; `byte` = FIFO head, or 0 when empty.
  - The acknowledged read pops the FIFO if non-empty.
  - Writes are ignored.
- Word 1, STAT:
  - bit0 NE (not empty), bit1 FULL, bit2 PERR, bit3 FERR, bit4 OVR, bit16 IE; other bits read 0.
  - Writing 1 with `sel_i[0]` clears PERR/FERR/OVR (W1C).
  - Writing with `sel_i[2]` loads IE from `dat_i[16]`.
  - Hardware set and W1C clear of the same flag in the same cycle: set wins.
- `irq_o` = IE & (NE | PERR | FERR | OVR).

## Timing
- Reset values:
  - Outputs: `ack_o`=0, `dat_o`=0, `irq_o`=0.
  - State: FSM IDLE, FIFO empty, PERR/FERR/OVR/IE=0, timeout counter 0.
- Reset mid-frame discards the partial frame; no flags are set.
- Wishbone:
  - `ack_o` asserts in the cycle after `cyc_i & stb_i` is sampled, for exactly one cycle.
  - `stb_i` still high in the ack cycle does not produce a second ack. Any slave access takes 2 cycles.
  - `dat_o` is registered and valid in the ack cycle. It holds its last value otherwise.
  - The FIFO pop and the W1C/IE register update take effect on the ack cycle edge.
- Pin latency: a pin transition is seen as an edge 3 `clk_i` cycles later.
- Push latency: the byte is in the FIFO, and NE is set, 1 cycle after the stop-bit edge is detected.
- `irq_o` is registered; it follows its condition by 1 cycle.

## Configuration
- `WB_PS2_IRQ_EN` defined: IE is implemented and `irq_o` behaves as described above.
- Not defined:
  - IE is not implemented; STAT bit16 reads 0 and writes to it are ignored.
  - `irq_o` is tied to 0.
  - Receive and FIFO behaviour is unchanged; software polls NE.

## Test plan
- Good frame: send frame 0x1C with parity 0 and stop 1, then read word 0. Required: `dat_o`=0x11C. A following read returns 0x000; STAT=0.
- Bad parity: send 0x1C with parity 1. Required: STAT=0x4, FIFO empty. Then write 0x4 to STAT; STAT reads 0.
- Overrun: send 17 frames 0x00..0x10 without reading. Required: STAT reads FULL=1 and OVR=1 (0x13). Sixteen reads return 0x100..0x10F, then a read returns 0x000.
- Timeout: send the start bit plus 3 data bits, then idle for `TIMEOUT` cycles. Required: FERR=1. A subsequent good frame 0xF0 reads back as 0x1F0.
- Simultaneous events: align the stop-bit push of a byte with the ack of a DATA read from a 1-entry FIFO. Required: the read returns the old byte and the new byte remains. Align a PERR set with a W1C write of PERR: PERR reads 1.
- IRQ (with `WB_PS2_IRQ_EN`): write IE=1 (0x10000), then receive one byte. Required: `irq_o` rises. A read of word 0 drops `irq_o` within 2 cycles after the ack.

Source files
------------

// File: rtl/wb_ps2.sv
// Wishbone B4 PS/2 receiver: synchronizer, frame FSM, byte FIFO, DATA/STAT regs.
// Define WB_PS2_IRQ_EN to build the IE bit and the irq_o output.
module wb_ps2 #(
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 50000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [29:0] adr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] dat_i,
  output logic        ack_o,
  output logic [31:0] dat_o,
  input  logic        ps2_clk,
  input  logic        ps2_dat,
  output logic        irq_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PAR,
    S_STOP
  } state_e;

  logic [1:0] ck_sync_q, dt_sync_q;
  logic       ck_hist_q, dt_hist_q;
  logic       fall_w, bit_w;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ck_sync_q <= 2'b11;
      dt_sync_q <= 2'b11;
      ck_hist_q <= 1'b1;
      dt_hist_q <= 1'b1;
    end else begin
      ck_sync_q <= {ck_sync_q[0], ps2_clk};
      dt_sync_q <= {dt_sync_q[0], ps2_dat};
      ck_hist_q <= ck_sync_q[1];
      dt_hist_q <= dt_sync_q[1];
    end
  end

  assign fall_w = ck_hist_q & ~ck_sync_q[1];
  assign bit_w  = dt_hist_q;

  state_e        state_q;
  logic [2:0]    bcnt_q;
  logic [7:0]    shift_q;
  logic          par_q;
  logic [CW-1:0] to_cnt_q;
  logic          to_ev_w, stop_ev_w, par_ok_w;
  logic          push_w, perr_set_w, ferr_set_w;

  assign to_ev_w = (state_q != S_IDLE) & ~fall_w & (to_cnt_q == TO_MAX);
  assign stop_ev_w = fall_w & (state_q == S_STOP);
  assign par_ok_w = ^{shift_q, par_q};
  assign push_w = stop_ev_w & bit_w & par_ok_w;
  assign perr_set_w = stop_ev_w & bit_w & ~par_ok_w;
  assign ferr_set_w = (stop_ev_w & ~bit_w) | to_ev_w;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      bcnt_q   <= 3'd0;
      shift_q  <= 8'h00;
      par_q    <= 1'b0;
      to_cnt_q <= '0;
    end else begin
      if (fall_w || to_ev_w || state_q == S_IDLE)
        to_cnt_q <= '0;
      else
        to_cnt_q <= to_cnt_q + 1'b1;
      if (to_ev_w) begin
        state_q <= S_IDLE;
      end else if (fall_w) begin
        unique case (state_q)
          S_IDLE: begin
            if (!bit_w) begin
              state_q <= S_DATA;
              bcnt_q  <= 3'd0;
            end
          end
          S_DATA: begin
            shift_q <= {bit_w, shift_q[7:1]};
            bcnt_q  <= bcnt_q + 3'd1;
            if (bcnt_q == 3'd7) state_q <= S_PAR;
          end
          S_PAR: begin
            par_q   <= bit_w;
            state_q <= S_STOP;
          end
          S_STOP: state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q;
  logic          empty_w, full_w, do_push_w, pop_w;

  assign empty_w   = (cnt_q == '0);
  assign full_w    = (cnt_q == FULL_CNT);
  assign do_push_w = push_w & ~full_w;

  always_ff @(posedge clk_i) begin
    if (do_push_w) mem_q[wptr_q] <= shift_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push_w) wptr_q <= wptr_q + 1'b1;
      if (pop_w) rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_q + {{AW{1'b0}}, do_push_w}
                     - {{AW{1'b0}}, pop_w};
    end
  end

  logic        ack_q;
  logic [31:0] dat_q;
  logic        req_w, wr_stat_w, w1c_w, ie_w;
  logic        perr_q, ferr_q, ovr_q;
  logic [31:0] stat_w, data_w;
  logic [7:0]  head_w;

  assign req_w     = cyc_i & stb_i & ~ack_q;
  assign pop_w     = req_w & ~we_i & ~adr_i[0] & ~empty_w;
  assign wr_stat_w = req_w & we_i & adr_i[0];
  assign w1c_w     = wr_stat_w & sel_i[0];
  assign head_w    = empty_w ? 8'h00 : mem_q[rptr_q];
  assign data_w    = {23'b0, ~empty_w, head_w};
  assign stat_w    = {15'b0, ie_w, 11'b0, ovr_q, ferr_q,
                      perr_q, full_w, ~empty_w};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_q <= 1'b0;
      dat_q <= 32'h0;
    end else begin
      ack_q <= req_w;
      if (req_w && !we_i)
        dat_q <= adr_i[0] ? stat_w : data_w;
    end
  end

  // Hardware set is ORed in after the clear so set wins.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      perr_q <= perr_set_w | (perr_q & ~(w1c_w & dat_i[2]));
      ferr_q <= ferr_set_w | (ferr_q & ~(w1c_w & dat_i[3]));
      ovr_q  <= (push_w & full_w)
              | (ovr_q & ~(w1c_w & dat_i[4]));
    end
  end

  assign ack_o = ack_q;
  assign dat_o = dat_q;

  logic unused_w;

`ifdef WB_PS2_IRQ_EN
  logic ie_q, irq_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ie_q  <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      if (wr_stat_w && sel_i[2]) ie_q <= dat_i[16];
      irq_q <= ie_q & (~empty_w | perr_q | ferr_q | ovr_q);
    end
  end

  assign ie_w  = ie_q;
  assign irq_o = irq_q;
  assign unused_w = ^{adr_i[29:1], sel_i[3], sel_i[1],
                      dat_i[31:17], dat_i[15:5], dat_i[1:0]};
`else
  assign ie_w  = 1'b0;
  assign irq_o = 1'b0;
  assign unused_w = ^{adr_i[29:1], sel_i[3:1],
                      dat_i[31:5], dat_i[1:0]};
`endif

endmodule
